// File: rtl/game_pkg.sv
// Shared constants for the game front-end and gameController.
//   DIR_*    move codes carried on the dir bus (DIR_IDLE = no move)
//   BTN_*    bit positions of the buttons in the top-level button vector
//   pick_dir lowest-code move among simultaneous press events
package game_pkg;

    localparam int DIR_W = 3;

    typedef logic [DIR_W-1:0] dir_t;

    localparam dir_t DIR_UP    = 3'd0;
    localparam dir_t DIR_DOWN  = 3'd1;
    localparam dir_t DIR_LEFT  = 3'd2;
    localparam dir_t DIR_RIGHT = 3'd3;
    localparam dir_t DIR_IDLE  = 3'd4;

    // Button vector layout: move buttons sit at the index equal to their
    // dir code, so the arbiter can emit the bit index directly.
    localparam int NUM_MOVES = 4;
    localparam int NUM_BTN   = 5;
    localparam int BTN_RESET = 4;

    function automatic dir_t pick_dir(input logic [NUM_MOVES-1:0] ev);
        pick_dir = DIR_IDLE;
        for (int i = NUM_MOVES - 1; i >= 0; i--) begin
            if (ev[i]) pick_dir = DIR_W'(i);
        end
    endfunction

endpackage

// File: rtl/dir_input_encoder_if.sv
// Button / move bus between the board-side buttons and the encoder.
//   btn_*            raw asynchronous buttons, active-high
//   dir              registered move code (DIR_IDLE when no move)
//   game_rst         registered active-high reset to gameController
//   cooldown_active  registered, high while moves are dropped
// master = button/controller side, slave = encoder.
interface dir_input_encoder_if;
    import game_pkg::*;

    logic btn_up;
    logic btn_down;
    logic btn_left;
    logic btn_right;
    logic btn_reset;
    dir_t dir;
    logic game_rst;
    logic cooldown_active;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_reset,
        input  dir, game_rst, cooldown_active
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_reset,
        output dir, game_rst, cooldown_active
    );

endinterface

// File: rtl/btn_debounce.sv
// One button lane: 2-flop synchronizer, stability counter, press detect.
//   clk, rst_n  clock / async active-low reset
//   raw         asynchronous button input
//   level       debounced button level
//   press       one-cycle pulse on an accepted 0->1 change of level
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int            CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            meta  <= raw;
            sync  <= meta;
            press <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Accept the new level; press is registered alongside it so
                // the event and the level change land on the same edge.
                level <= sync;
                press <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dir_input_encoder.sv
// Push-button front-end for gameController.
//   clk, rst_n  clock / async active-low reset
//   bus         dir_input_encoder_if.slave: raw buttons in; dir, game_rst,
//               cooldown_active out (all registered)
// Five debounce lanes feed a registered arbiter. A reset-button press
// restarts the game_rst pulse and wins over any move; an issued move opens
// a cooldown window that drops (never queues) later move presses.
module dir_input_encoder
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int COOLDOWN_CYCLES  = 256,
    parameter int RST_PULSE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    dir_input_encoder_if.slave  bus
);

    localparam int              RW       = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
    localparam logic [RW-1:0]   RST_LAST = RW'(RST_PULSE_CYCLES - 1);
    localparam int              CW       = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
    localparam logic [CW-1:0]   CD_LOAD  = CW'(COOLDOWN_CYCLES);
    // With a zero-length cooldown the flag never rises.
    localparam logic            CD_EN    = (COOLDOWN_CYCLES != 0);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] ev;

    dir_t          dir_q;
    logic          game_rst_q;
    logic          cd_q;
    logic [RW-1:0] rst_cnt;
    logic [CW-1:0] cd_cnt;
    logic          move_ok;

    assign raw = {bus.btn_reset, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn [NUM_BTN-1:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw),
        .level (level),
        .press (press)
    );

    // press and level move on the same edge, so gating by level only
    // restates that an event belongs to a button currently held.
    assign ev = press & level;

    // Idle-before-issue keeps dir from being non-idle on adjacent cycles
    // even when cooldown is disabled.
    assign move_ok = (|ev[NUM_MOVES-1:0]) && !game_rst_q && !cd_q && (dir_q == DIR_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q      <= DIR_IDLE;
            game_rst_q <= 1'b1;
            rst_cnt    <= '0;
            cd_q       <= 1'b0;
            cd_cnt     <= '0;
        end else begin
            dir_q <= DIR_IDLE;
            if (ev[BTN_RESET]) begin
                game_rst_q <= 1'b1;
                rst_cnt    <= '0;
                cd_q       <= 1'b0;
                cd_cnt     <= '0;
            end else begin
                if (game_rst_q) begin
                    if (rst_cnt == RST_LAST) begin
                        game_rst_q <= 1'b0;
                        rst_cnt    <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                if (move_ok) begin
                    dir_q  <= pick_dir(ev[NUM_MOVES-1:0]);
                    cd_q   <= CD_EN;
                    cd_cnt <= CD_LOAD;
                end else if (cd_q) begin
                    if (cd_cnt == '0) cd_q <= 1'b0;
                    else              cd_cnt <= cd_cnt - 1'b1;
                end
            end
        end
    end

    assign bus.dir             = dir_q;
    assign bus.game_rst        = game_rst_q;
    assign bus.cooldown_active = cd_q;

endmodule
